// File: rtl/div_seq.sv
// Iterative signed divider: 2N-bit dividend / N-bit divisor, restoring on magnitudes,
// one quotient bit per clock. Optional remainder output enabled by macro DIV_REM_EN.
module div_seq #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     q,
    output logic [N-1:0]     r,
    output logic             div0,
    output logic             ovf
);

    localparam logic [1:0]   S_IDLE   = 2'd0;
    localparam logic [1:0]   S_CALC   = 2'd1;
    localparam logic [1:0]   S_FIX    = 2'd2;
    localparam logic [N-1:0] Q_MAX    = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] Q_MIN    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CNT_LAST = N'(N-1);

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
        return ~v + ONE_N;
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
        return ~v + {{(2*N-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]     state_r;
    logic [N-1:0]   cnt_r;
    logic [2*N-1:0] rem_r;
    logic [N-1:0]   b_abs_r;
    logic           sign_q_r;
    logic           div0_pend_r;
    logic           eovf_r;
    logic           fix_ph_r;
    logic [N-1:0]   res_q_r;
    logic [N-1:0]   res_r_r;
    logic           res_div0_r;
    logic           res_ovf_r;
    logic [N-1:0]   q_r;
    logic [N-1:0]   r_r;
    logic           div0_r;
    logic           ovf_r;
    logic           busy_r;
    logic           done_r;
`ifdef DIV_REM_EN
    logic           sign_r_r;
    logic [N-1:0]   a_lo_r;
    logic [N-1:0]   mag_r_s;
`endif

    logic [2*N-1:0] a_abs_s;
    logic [N-1:0]   b_abs_s;
    logic           early_ovf_s;
    logic [2*N:0]   shifted_s;
    logic [N:0]     diff_s;
    logic [N-1:0]   mag_q_s;
    logic           calc_ovf_s;
    logic [N-1:0]   fix_q_s;
    logic [N-1:0]   fix_r_s;
    logic           fix_ovf_s;

    // |a| is 2N-bit unsigned so the most negative dividend still fits
    assign a_abs_s     = a[2*N-1] ? neg_2n(a) : a;
    assign b_abs_s     = b[N-1] ? neg_n(b) : b;
    assign early_ovf_s = (a_abs_s[2*N-1:N] >= b_abs_s);
    assign shifted_s   = {rem_r, 1'b0};
    assign diff_s      = shifted_s[2*N:N] - {1'b0, b_abs_r};
    assign mag_q_s     = rem_r[N-1:0];
    assign calc_ovf_s  = sign_q_r ? (mag_q_s > Q_MIN) : (mag_q_s > Q_MAX);
`ifdef DIV_REM_EN
    assign mag_r_s     = rem_r[2*N-1:N];
`endif

    // Final signed result: div0 beats overflow, overflow saturates by quotient sign
    always_comb begin
        fix_q_s   = mag_q_s;
        fix_r_s   = {N{1'b0}};
        fix_ovf_s = 1'b0;
        if (div0_pend_r) begin
            fix_q_s = {N{1'b1}};
`ifdef DIV_REM_EN
            fix_r_s = a_lo_r;
`else
            fix_r_s = {N{1'b0}};
`endif
        end else if (eovf_r || calc_ovf_s) begin
            fix_q_s   = sign_q_r ? Q_MIN : Q_MAX;
            fix_ovf_s = 1'b1;
        end else begin
            fix_q_s = sign_q_r ? neg_n(mag_q_s) : mag_q_s;
`ifdef DIV_REM_EN
            fix_r_s = sign_r_r ? neg_n(mag_r_s) : mag_r_s;
`else
            fix_r_s = {N{1'b0}};
`endif
        end
    end

    // Control FSM, restoring datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= {N{1'b0}};
            rem_r       <= {(2*N){1'b0}};
            b_abs_r     <= {N{1'b0}};
            sign_q_r    <= 1'b0;
            div0_pend_r <= 1'b0;
            eovf_r      <= 1'b0;
            fix_ph_r    <= 1'b0;
            res_q_r     <= {N{1'b0}};
            res_r_r     <= {N{1'b0}};
            res_div0_r  <= 1'b0;
            res_ovf_r   <= 1'b0;
            q_r         <= {N{1'b0}};
            r_r         <= {N{1'b0}};
            div0_r      <= 1'b0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef DIV_REM_EN
            sign_r_r    <= 1'b0;
            a_lo_r      <= {N{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        rem_r       <= a_abs_s;
                        b_abs_r     <= b_abs_s;
                        sign_q_r    <= a[2*N-1] ^ b[N-1];
                        cnt_r       <= {N{1'b0}};
                        fix_ph_r    <= 1'b0;
                        busy_r      <= 1'b1;
                        div0_pend_r <= (b == {N{1'b0}});
                        eovf_r      <= early_ovf_s;
`ifdef DIV_REM_EN
                        sign_r_r    <= a[2*N-1];
                        a_lo_r      <= a[N-1:0];
`endif
                        if ((b == {N{1'b0}}) || early_ovf_s) begin
                            state_r <= S_FIX;
                        end else begin
                            state_r <= S_CALC;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (!diff_s[N]) begin
                        rem_r <= {diff_s[N-1:0], shifted_s[N-1:1], 1'b1};
                    end else begin
                        rem_r <= shifted_s[2*N-1:0];
                    end
                    cnt_r <= cnt_r + ONE_N;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_CALC;
                    end
                end
                S_FIX: begin
                    // Sign fix-up is staged one cycle before the outputs are published
                    if (!fix_ph_r) begin
                        res_q_r    <= fix_q_s;
                        res_r_r    <= fix_r_s;
                        res_div0_r <= div0_pend_r;
                        res_ovf_r  <= fix_ovf_s;
                        fix_ph_r   <= 1'b1;
                    end else begin
                        q_r      <= res_q_r;
                        r_r      <= res_r_r;
                        div0_r   <= res_div0_r;
                        ovf_r    <= res_ovf_r;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        fix_ph_r <= 1'b0;
                        state_r  <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign q    = q_r;
    assign r    = r_r;
    assign div0 = div0_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vectors, handshake corner cases,
// multiplier loopback and random ops against an arithmetic reference model.
module tb_div_seq;

`ifdef DIV_REM_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        div0;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       div0;
        logic       ovf;
        logic [7:0] lat;
    } exp_t;

    div_seq #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .div0(div0), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer division truncates toward zero, % takes the dividend's sign
    function automatic exp_t model(input logic [15:0] av, input logic [7:0] bv);
        exp_t e;
        int ai, bi, aa, ab, tq, tr;
        ai = $signed(av);
        bi = $signed(bv);
        e  = '0;
        if (bi == 0) begin
            e.q    = 8'hFF;
            e.r    = REM_EN ? av[7:0] : 8'h00;
            e.div0 = 1'b1;
            e.lat  = 8'd2;
        end else begin
            aa = (ai < 0) ? -ai : ai;
            ab = (bi < 0) ? -bi : bi;
            tq = ai / bi;
            tr = ai % bi;
            e.lat = ((aa / 256) >= ab) ? 8'd2 : 8'd10;
            if (tq > 127) begin
                e.q = 8'h7F; e.ovf = 1'b1;
            end else if (tq < -128) begin
                e.q = 8'h80; e.ovf = 1'b1;
            end else begin
                e.q = tq[7:0];
                e.r = REM_EN ? tr[7:0] : 8'h00;
            end
        end
        return e;
    endfunction

    // Launch one op from just after a rising edge; lat counts edges until done shows
    task automatic run_op(input logic [15:0] av, input logic [7:0] bv, output int lat);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 16'h0000; b = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, q, r, div0, ovf} !== 20'h00000) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b q=%h r=%h div0=%b ovf=%b, want all 0",
                     busy, done, q, r, div0, ovf);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [11] = '{16'h0064, 16'hFF9C, 16'h0064, 16'h0100, 16'h4000, 16'h0080,
                                 16'hFF80, 16'h7FFF, 16'h8000, 16'h0005, 16'hFFFF};
        logic [7:0]  vb [11] = '{8'h07, 8'h07, 8'hF9, 8'h00, 8'h02, 8'h01,
                                 8'h01, 8'h80, 8'hFF, 8'h00, 8'h00};
        logic [7:0]  vq [11] = '{8'h0E, 8'hF2, 8'hF2, 8'hFF, 8'h7F, 8'h7F,
                                 8'h80, 8'h80, 8'h7F, 8'hFF, 8'hFF};
        logic [7:0]  vr [11] = '{8'h02, 8'hFE, 8'h02, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h05, 8'hFF};
        logic [1:0]  vf [11] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01,
                                 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
        int          vl [11] = '{10, 10, 10, 2, 2, 10, 10, 10, 2, 2, 2};
        int lat;
        logic [7:0] er;
        for (int i = 0; i < 11; i++) begin
            run_op(va[i], vb[i], lat);
            er = REM_EN ? vr[i] : 8'h00;
            n_cmp++;
            if (lat !== vl[i] || q !== vq[i] || r !== er || {div0, ovf} !== vf[i] || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed[%0d] a=%h b=%h: lat=%0d q=%h r=%h div0/ovf=%b%b busy=%b, want lat=%0d q=%h r=%h div0/ovf=%b busy=0",
                         i, va[i], vb[i], lat, q, r, div0, ovf, busy, vl[i], vq[i], er, vf[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int extra;
        logic [7:0] er;
        a = 16'd100; b = 8'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: busy=%b, want 1", busy);
        end
        repeat (2) @(posedge clk);
        #1 a = 16'h0100; b = 8'h00; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 3;
        while (lat < 40 && done !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        er = REM_EN ? 8'h02 : 8'h00;
        n_cmp++;
        if (lat !== 10 || q !== 8'h0E || r !== er || div0 !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore: lat=%0d q=%h r=%h div0=%b, want lat=10 q=0e r=%h div0=0",
                     lat, q, r, div0, er);
        end
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL no_queued_op: activity cycles=%0d, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        exp_t e;
        run_op(16'hFF9C, 8'h07, lat);
        // Start is raised in the done cycle itself
        run_op(16'd1000, 8'd9, lat);
        e = model(16'd1000, 8'd9);
        n_cmp++;
        if (lat !== 10 || q !== e.q || r !== e.r || ovf !== e.ovf) begin
            n_err++;
            $display("FAIL back_to_back: lat=%0d q=%h r=%h ovf=%b, want lat=10 q=%h r=%h ovf=%b",
                     lat, q, r, ovf, e.q, e.r, e.ovf);
        end
    endtask

    task automatic test_rst_abort();
        int lat;
        a = 16'hFF9C; b = 8'h07; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || q !== 8'h00 || r !== 8'h00 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_abort: busy=%b q=%h r=%h done=%b, want 0 00 00 0", busy, q, r, done);
        end
        rst = 1'b0;
        run_op(16'd100, 8'd7, lat);
        n_cmp++;
        if (lat !== 10 || q !== 8'h0E) begin
            n_err++;
            $display("FAIL after_abort: lat=%0d q=%h, want lat=10 q=0e", lat, q);
        end
    endtask

    task automatic test_loopback();
        int lat, xi, yi, p;
        logic [7:0] x, y;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                xi = -128; yi = -1;
            end else if (i == 1) begin
                xi = -128; yi = -128;
            end else begin
                xi = $urandom_range(0, 255) - 128;
                yi = $urandom_range(0, 254) - 128;
                if (yi >= 0) yi++;
            end
            x = xi[7:0]; y = yi[7:0];
            p = xi * yi;
            run_op(p[15:0], y, lat);
            // Every product divides back exactly, including (-128*-1)/-1 = -128
            n_cmp++;
            if (lat !== 10 || q !== x || r !== 8'h00 || ovf !== 1'b0 || div0 !== 1'b0) begin
                n_err++;
                $display("FAIL loopback x=%0d y=%0d: lat=%0d q=%h r=%h ovf=%b div0=%b, want lat=10 q=%h r=00 ovf=0 div0=0",
                         xi, yi, lat, q, r, ovf, div0, x);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        exp_t e;
        logic [15:0] av;
        logic [7:0] bv;
        for (int i = 0; i < 60; i++) begin
            av = 16'($urandom);
            case (i % 4)
                0:       av = {{8{av[15]}}, av[7:0]};
                1:       bv = 8'h00;
                default: bv = 8'h00;
            endcase
            bv = (i % 10 == 5) ? 8'h00 : 8'($urandom);
            e = model(av, bv);
            run_op(av, bv, lat);
            n_cmp++;
            if (lat !== int'(e.lat) || q !== e.q || r !== e.r || div0 !== e.div0 || ovf !== e.ovf) begin
                n_err++;
                $display("FAIL random a=%h b=%h: lat=%0d q=%h r=%h div0=%b ovf=%b, want lat=%0d q=%h r=%h div0=%b ovf=%b",
                         av, bv, lat, q, r, div0, ovf, e.lat, e.q, e.r, e.div0, e.ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_rst_abort();
        test_loopback();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
